mips_trace_fifo: RTL and testbench
==================================

# mips_trace_fifo

Retirement trace buffer that sits directly downstream of `MIPS_TOP`. Each cycle it can capture the core's retired `{PC, instruction, wb_value}` triple into a first-word-fall-through FIFO. It presents the entries to a debug or trace consumer over a valid/ready interface. Overflow is detected, counted and flagged, so a slow consumer never stalls the core and never silently corrupts the trace.

## Interface
- `DEPTH`, default 16: number of entries; must be a power of two, 2 to 256.
- `ADDR_W`, default 4: equals log2(`DEPTH`).
- `FILTER_NOP`, default 0: when 1, triples with `in_instr == 32'h0000_0000` are discarded.
- `clk`  input  1  sole clock; all state updates on the rising edge.
- `reset`  input  1  asynchronous, active-low reset.
- `clear`  input  1  synchronous flush of contents, `overflow` and `drop_cnt`.
- `in_valid`  input  1  the core retired an instruction this cycle.
- `in_pc`  input  32  PC of the retired instruction.
- `in_instr`  input  32  retired instruction word.
- `in_wb`  input  32  write-back value.
- `out_valid`  output  1  head entry is valid.
- `out_ready`  input  1  consumer accepts the head entry this cycle.
- `out_pc`  output  32  head entry PC.
- `out_instr`  output  32  head entry instruction.
- `out_wb`  output  32  head entry write-back value.
- `count`  output  ADDR_W+1  number of stored entries, 0 to `DEPTH`.
- `overflow`  output  1  sticky flag: at least one triple was dropped.
- `drop_cnt`  output  16  number of dropped triples, saturating.

## Operation
- Storage: `DEPTH` x 96-bit array, a write pointer and a read pointer, each `ADDR_W` bits and wrapping modulo `DEPTH`, plus an `ADDR_W+1`-bit occupancy counter.
- Events decoded each cycle:
  - push_req = `in_valid` and not (`FILTER_NOP` and `in_instr == 0`).
  - pop = `out_valid` and `out_ready`.
- Push is accepted when push_req and (`count < DEPTH` or pop).
  - A full FIFO with a simultaneous pop accepts the push; `count` stays at `DEPTH`.
- Drop occurs when push_req and `count == DEPTH` and not pop.
  - The triple is discarded and `overflow` is set to 1.
  - `drop_cnt` increments, saturating at 16'hFFFF.
- Filtered NOPs are neither stored nor counted as drops.
- `count` next value = `count` + push − pop.
- `out_valid` = (`count != 0`).
- `out_pc`, `out_instr` and `out_wb` show the entry at the read pointer, with no read latency. They are forced to 0 when `count == 0`.
- Head outputs stay stable while `out_valid` is high and `out_ready` is low.
- Priority, highest first:
  1. `reset` low: pointers, `count`, `overflow` and `drop_cnt` go to 0 immediately.
  2. `clear` high: same targets as reset at the next edge; push and pop in that cycle are ignored and produce no drop.
  3. Normal push/pop.
- Array contents are not reset; they are don't-care while unoccupied.
- There is no bypass: a push into an empty FIFO is not visible at the outputs in the same cycle.

## Timing
- Reset values: `out_valid` 0, `out_pc`/`out_instr`/`out_wb` 0, `count` 0, `overflow` 0, `drop_cnt` 0.
- Reset assertion takes effect asynchronously. Deassertion is sampled at the next rising edge of `clk`.
- Latency from push to output:
  - Triple presented with `in_valid` in cycle N.
  - `out_valid` high and data on `out_*` from cycle N+1.
- Pop: the head is consumed at the edge ending cycle N. The next entry, or `out_valid` = 0, appears in cycle N+1.
- Throughput: one push and one pop per cycle, sustained, at any occupancy.
- Flags:
  - `overflow` and `drop_cnt` update at the edge ending the dropping cycle.
  - `overflow` holds until `reset` or `clear`.
- Wrap-around: pointers roll from `DEPTH-1` to 0 with no bubble.
- Reset mid-stream: every in-flight entry is lost. The first push after reset is the first entry out.

## Test plan
- Basic order: push PCs 0x00, 0x04 and 0x08 with `out_ready` = 0, then raise `out_ready`.
  - Required: `count` reaches 3.
  - Required: `out_pc` reads 0x00, 0x04, 0x08 on consecutive cycles, with matching instr/wb.
  - Required: `out_valid` falls the cycle after the third pop.
- Overflow: with `DEPTH` = 16 and `out_ready` = 0, push 20 triples.
  - Required: `count` = 16, `overflow` = 1, `drop_cnt` = 4.
  - Required: draining returns the first 16 PCs unchanged.
- Full with simultaneous push/pop: fill to 16, then hold `in_valid` = 1 and `out_ready` = 1 for 40 cycles.
  - Required: `count` stays 16, `drop_cnt` stays 0.
  - Required: order is preserved across multiple pointer wraps.
- Clear and reset: with 5 entries stored and `drop_cnt` = 3, pulse `clear` together with `in_valid`.
  - Required after `clear`: `count` = 0, `overflow` = 0, `drop_cnt` = 0, and nothing is stored.
  - Repeat the setup and drive `reset` low mid-cycle.
  - Required: all outputs are 0 before the next clock edge.
- NOP filter: with `FILTER_NOP` = 1, push instr 0x00000000, then instr 0x20080005.
  - Required: only 0x20080005 appears, `count` = 1, `drop_cnt` = 0.
- Back-pressure stability: stall `out_ready` low for 7 cycles while `out_valid` is high.
  - Required: `out_pc`, `out_instr` and `out_wb` are unchanged throughout, while pushes still increment `count`.

Source files
------------

// File: rtl/mips_trace_fifo.sv
// mips_trace_fifo: first-word-fall-through trace buffer for retired
// {PC, instruction, write-back} triples. When the buffer is full, a new
// triple is dropped and counted instead of stalling the core.
module mips_trace_fifo #(
    parameter int DEPTH      = 16,
    parameter int ADDR_W     = 4,
    parameter bit FILTER_NOP = 1'b0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              in_valid,
    input  logic [31:0]       in_pc,
    input  logic [31:0]       in_instr,
    input  logic [31:0]       in_wb,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_pc,
    output logic [31:0]       out_instr,
    output logic [31:0]       out_wb,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    output logic [15:0]       drop_cnt
);

    localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);

    logic [95:0]       mem_q [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              overflow_q, overflow_d;
    logic [15:0]       drop_cnt_q, drop_cnt_d;

    logic              push_req;
    logic              pop;
    logic              push_acc;
    logic              drop;
    logic [95:0]       head;

    // Decode this cycle's push, pop and drop events; a pop frees the slot a full-buffer push needs
    always_comb begin
        push_req = in_valid && !(FILTER_NOP && (in_instr == 32'h0000_0000));
        pop      = out_valid && out_ready;
        push_acc = push_req && ((count_q != FULL_CNT) || pop);
        drop     = push_req && (count_q == FULL_CNT) && !pop;
    end

    // Next-state for pointers, occupancy and overflow bookkeeping; clear overrides everything
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        drop_cnt_d = drop_cnt_q;
        if (clear) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            overflow_d = 1'b0;
            drop_cnt_d = 16'h0000;
        end else begin
            if (push_acc) begin
                wr_ptr_d = wr_ptr_q + ADDR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + ADDR_W'(1);
            end
            if (push_acc && !pop) begin
                count_d = count_q + (ADDR_W+1)'(1);
            end else if (pop && !push_acc) begin
                count_d = count_q - (ADDR_W+1)'(1);
            end
            if (drop) begin
                overflow_d = 1'b1;
                if (drop_cnt_q != 16'hFFFF) begin
                    drop_cnt_d = drop_cnt_q + 16'd1;
                end
            end
        end
    end

    // Control state register with asynchronous active-low reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            drop_cnt_q <= 16'h0000;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    // Storage array is not reset; unoccupied slots are don't-care
    always_ff @(posedge clk) begin
        if (push_acc && !clear) begin
            mem_q[wr_ptr_q] <= {in_pc, in_instr, in_wb};
        end
    end

    // Head presentation with no read latency, zeroed while the buffer is empty
    always_comb begin
        out_valid = (count_q != '0);
        head      = mem_q[rd_ptr_q];
        out_pc    = 32'h0;
        out_instr = 32'h0;
        out_wb    = 32'h0;
        if (out_valid) begin
            out_pc    = head[95:64];
            out_instr = head[63:32];
            out_wb    = head[31:0];
        end
        count    = count_q;
        overflow = overflow_q;
        drop_cnt = drop_cnt_q;
    end

endmodule

// File: tb/tb_mips_trace_fifo.sv
// tb_mips_trace_fifo: drives two buffers (NOP filter off and on) with the same
// stimulus and compares them every cycle against queue-based reference models.
module tb_mips_trace_fifo;

    localparam int DEPTH  = 16;
    localparam int ADDR_W = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        clear;
    logic        in_valid;
    logic [31:0] in_pc;
    logic [31:0] in_instr;
    logic [31:0] in_wb;
    logic        out_ready;

    logic              out_valid_a, out_valid_f;
    logic [31:0]       out_pc_a, out_pc_f;
    logic [31:0]       out_instr_a, out_instr_f;
    logic [31:0]       out_wb_a, out_wb_f;
    logic [ADDR_W:0]   count_a, count_f;
    logic              overflow_a, overflow_f;
    logic [15:0]       drop_cnt_a, drop_cnt_f;

    int vec_count  = 0;
    int miss_count = 0;

    logic [95:0] q_a[$];
    logic [95:0] q_f[$];
    bit          ovf_a, ovf_f;
    int          drop_a, drop_f;

    mips_trace_fifo #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .FILTER_NOP(1'b0)) dut_a (
        .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid),
        .in_pc(in_pc), .in_instr(in_instr), .in_wb(in_wb),
        .out_valid(out_valid_a), .out_ready(out_ready), .out_pc(out_pc_a),
        .out_instr(out_instr_a), .out_wb(out_wb_a), .count(count_a),
        .overflow(overflow_a), .drop_cnt(drop_cnt_a)
    );

    mips_trace_fifo #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .FILTER_NOP(1'b1)) dut_f (
        .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid),
        .in_pc(in_pc), .in_instr(in_instr), .in_wb(in_wb),
        .out_valid(out_valid_f), .out_ready(out_ready), .out_pc(out_pc_f),
        .out_instr(out_instr_f), .out_wb(out_wb_f), .count(count_f),
        .overflow(overflow_f), .drop_cnt(drop_cnt_f)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vec_count++;
        if (obs !== exp) begin
            miss_count++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic modelClear();
        q_a.delete();
        q_f.delete();
        ovf_a  = 1'b0;
        ovf_f  = 1'b0;
        drop_a = 0;
        drop_f = 0;
    endtask

    // Advance both reference models by one clock edge using the current inputs
    task automatic modelUpdate();
        logic [95:0] trip;
        bit          pop_a, pop_f;
        trip = {in_pc, in_instr, in_wb};
        if (!reset || clear) begin
            modelClear();
        end else begin
            pop_a = (q_a.size() != 0) && out_ready;
            pop_f = (q_f.size() != 0) && out_ready;
            if (pop_a) q_a.delete(0);
            if (pop_f) q_f.delete(0);
            if (in_valid) begin
                if (q_a.size() < DEPTH) q_a.push_back(trip);
                else begin
                    ovf_a = 1'b1;
                    if (drop_a < 65535) drop_a++;
                end
            end
            if (in_valid && in_instr != 32'h0) begin
                if (q_f.size() < DEPTH) q_f.push_back(trip);
                else begin
                    ovf_f = 1'b1;
                    if (drop_f < 65535) drop_f++;
                end
            end
        end
    endtask

    task automatic checkAll();
        logic [95:0] ha, hf;
        ha = (q_a.size() != 0) ? q_a[0] : 96'h0;
        hf = (q_f.size() != 0) ? q_f[0] : 96'h0;
        checkOutput("a.valid", 64'(out_valid_a), 64'(q_a.size() != 0));
        checkOutput("a.pc",    64'(out_pc_a),    64'(ha[95:64]));
        checkOutput("a.instr", 64'(out_instr_a), 64'(ha[63:32]));
        checkOutput("a.wb",    64'(out_wb_a),    64'(ha[31:0]));
        checkOutput("a.count", 64'(count_a),     64'(q_a.size()));
        checkOutput("a.ovf",   64'(overflow_a),  64'(ovf_a));
        checkOutput("a.drop",  64'(drop_cnt_a),  64'(drop_a));
        checkOutput("f.valid", 64'(out_valid_f), 64'(q_f.size() != 0));
        checkOutput("f.pc",    64'(out_pc_f),    64'(hf[95:64]));
        checkOutput("f.instr", 64'(out_instr_f), 64'(hf[63:32]));
        checkOutput("f.wb",    64'(out_wb_f),    64'(hf[31:0]));
        checkOutput("f.count", 64'(count_f),     64'(q_f.size()));
        checkOutput("f.ovf",   64'(overflow_f),  64'(ovf_f));
        checkOutput("f.drop",  64'(drop_cnt_f),  64'(drop_f));
    endtask

    task automatic applyStimulus(input logic v, input logic [31:0] pc, input logic [31:0] instr,
                                 input logic [31:0] wb, input logic rdy, input logic clr);
        in_valid  = v;
        in_pc     = pc;
        in_instr  = instr;
        in_wb     = wb;
        out_ready = rdy;
        clear     = clr;
        modelUpdate();
        @(posedge clk);
        #1;
        checkAll();
    endtask

    task automatic pushN(input int n, input logic [31:0] base, input logic rdy);
        for (int i = 0; i < n; i++) begin
            applyStimulus(1'b1, base + 32'(i * 4), $urandom | 32'h1, $urandom, rdy, 1'b0);
        end
    endtask

    task automatic idleN(input int n, input logic rdy);
        for (int i = 0; i < n; i++) begin
            applyStimulus(1'b0, 32'h0, 32'h0, 32'h0, rdy, 1'b0);
        end
    endtask

    // Five entries stored with three drops recorded
    task automatic setupFiveWithDrops();
        pushN(DEPTH + 3, 32'h0000_2000, 1'b0);
        idleN(DEPTH - 5, 1'b1);
    endtask

    initial begin
        logic [31:0] held_pc, held_instr, held_wb;
        reset     = 1'b1;
        clear     = 1'b0;
        in_valid  = 1'b0;
        in_pc     = 32'h0;
        in_instr  = 32'h0;
        in_wb     = 32'h0;
        out_ready = 1'b0;
        modelClear();
        #2 reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkAll();
        reset = 1'b1;

        $display("[TB] basic order");
        applyStimulus(1'b1, 32'h0000_0000, 32'h2008_0001, 32'h0000_0011, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h0000_0004, 32'h2008_0002, 32'h0000_0022, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h0000_0008, 32'h2008_0003, 32'h0000_0033, 1'b0, 1'b0);
        checkOutput("basic.count3", 64'(count_a), 64'd3);
        idleN(4, 1'b1);

        $display("[TB] overflow");
        pushN(20, 32'h0000_0100, 1'b0);
        checkOutput("ovf.drop4", 64'(drop_cnt_a), 64'd4);
        idleN(DEPTH + 1, 1'b1);
        applyStimulus(1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1);

        $display("[TB] full with simultaneous push/pop");
        pushN(DEPTH, 32'h0000_1000, 1'b0);
        pushN(40, 32'h0000_1100, 1'b1);
        idleN(DEPTH + 1, 1'b1);

        $display("[TB] clear");
        setupFiveWithDrops();
        checkOutput("clr.pre_drop", 64'(drop_cnt_a), 64'd3);
        applyStimulus(1'b1, 32'h0000_3000, 32'h2008_0009, 32'h1, 1'b1, 1'b1);
        idleN(2, 1'b1);

        $display("[TB] reset mid-cycle");
        setupFiveWithDrops();
        #2 reset = 1'b0;
        #1;
        modelClear();
        checkAll();
        @(posedge clk);
        #1;
        checkAll();
        #2 reset = 1'b1;
        pushN(2, 32'h0000_4000, 1'b1);
        idleN(3, 1'b1);

        $display("[TB] NOP filter");
        applyStimulus(1'b1, 32'h0000_5000, 32'h0000_0000, 32'hAAAA, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h0000_5004, 32'h2008_0005, 32'hBBBB, 1'b0, 1'b0);
        checkOutput("nop.f_instr", 64'(out_instr_f), 64'h2008_0005);
        idleN(3, 1'b1);

        $display("[TB] back-pressure stability");
        pushN(2, 32'h0000_6000, 1'b0);
        held_pc    = out_pc_a;
        held_instr = out_instr_a;
        held_wb    = out_wb_a;
        for (int i = 0; i < 7; i++) begin
            applyStimulus(1'b1, 32'h0000_6100 + 32'(i * 4), $urandom | 32'h1, $urandom, 1'b0, 1'b0);
            checkOutput("bp.pc",    64'(out_pc_a),    64'(held_pc));
            checkOutput("bp.instr", 64'(out_instr_a), 64'(held_instr));
            checkOutput("bp.wb",    64'(out_wb_a),    64'(held_wb));
        end
        idleN(DEPTH, 1'b1);

        $display("[TB] random traffic");
        for (int i = 0; i < 400; i++) begin
            logic rdy;
            logic [31:0] ins;
            rdy = (((i / 50) % 2) == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            ins = ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom;
            applyStimulus($urandom_range(0, 3) != 0, $urandom, ins, $urandom, rdy,
                          $urandom_range(0, 99) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
        $finish;
    end

endmodule
